// File: rtl/uart_loader_pkg.sv
// Shared constants and FSM state encoding for the UART boot loader.
package uart_loader_pkg;

    localparam logic [7:0] SYNC      = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RESP
    } state_t;

endpackage

// File: rtl/uart_loader_byte_reader.sv
// Pops the UART RX buffer one byte at a time and presents each byte for one cycle.
// uart_read: pop issued when data_ready is seen and no pop is already outstanding;
// byte_valid/byte_data: the popped byte, one cycle after uart_read.
module uart_loader_byte_reader (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_data_ready,
    input  logic [7:0] uart_data_read,
    output logic       uart_read,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            uart_read  <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            // Never pop on consecutive cycles: the buffer's ready flag lags a pop.
            uart_read  <= uart_data_ready & ~uart_read;
            byte_valid <= uart_read;
        end
    end

    assign byte_data = uart_data_read;

endmodule

// File: rtl/uart_boot_loader.sv
// Framed UART boot loader: writes LE words into memory, answers ACK/NAK, gates cpu_hold.
// Optional inter-byte timeout is compiled in with `define UART_LOADER_TIMEOUT_EN.
module uart_boot_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  uart_data_ready,
    input  logic [7:0]            uart_data_read,
    output logic                  uart_read,
    output logic                  uart_write,
    output logic [7:0]            uart_data_write,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_data,
    output logic                  cpu_hold,
    output logic                  load_error
);

    logic                  byte_valid;
    logic [7:0]            byte_data;
    state_t                state, state_next;
    logic [1:0]            idx;
    logic [31:0]           addr_sh, addr_next;
    logic [15:0]           len_sh, len_next, len_rem;
    logic [31:0]           word_sh, word_next;
    logic [7:0]            csum;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  timeout_hit;

    uart_loader_byte_reader rd (
        .clock          (clock),
        .reset          (reset),
        .uart_data_ready(uart_data_ready),
        .uart_data_read (uart_data_read),
        .uart_read      (uart_read),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data)
    );

    assign addr_next = {byte_data, addr_sh[31:8]};
    assign len_next  = {byte_data, len_sh[15:8]};
    assign word_next = {byte_data, word_sh[31:8]};

`ifdef UART_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            to_cnt <= '0;
        else if (byte_valid || state == S_IDLE)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    // Decided one cycle early so the NAK leaves exactly TIMEOUT_CYCLES after the last byte.
    assign timeout_hit = (state != S_IDLE) && (state != S_RESP) && !byte_valid &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 2));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (timeout_hit) begin
            state_next = S_RESP;
        end else begin
            case (state)
                S_IDLE: if (byte_valid && byte_data == SYNC) state_next = S_CMD;
                S_CMD:  if (byte_valid) state_next = (byte_data == CMD_WRITE) ? S_ADDR : S_RESP;
                S_ADDR: if (byte_valid && idx == 2'd3) state_next = S_LEN;
                S_LEN:  if (byte_valid && idx == 2'd1)
                            state_next = (len_next == 16'd0) ? S_CSUM : S_DATA;
                S_DATA: if (byte_valid && idx == 2'd3 && len_rem == 16'd1) state_next = S_CSUM;
                S_CSUM: if (byte_valid) state_next = S_RESP;
                S_RESP: state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        uart_write = (state == S_RESP);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx             <= 2'd0;
            addr_sh         <= '0;
            len_sh          <= '0;
            len_rem         <= '0;
            word_sh         <= '0;
            csum            <= '0;
            waddr           <= '0;
            uart_data_write <= '0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_data        <= '0;
            cpu_hold        <= 1'b1;
            load_error      <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            if (timeout_hit) begin
                uart_data_write <= NAK;
                load_error      <= 1'b1;
            end else if (byte_valid) begin
                case (state)
                    S_IDLE: begin
                        csum <= '0;
                        idx  <= 2'd0;
                    end
                    S_CMD: begin
                        csum <= csum ^ byte_data;
                        idx  <= 2'd0;
                        if (byte_data == CMD_WRITE) begin
                            cpu_hold <= 1'b1;
                        end else if (byte_data == CMD_RUN) begin
                            cpu_hold        <= 1'b0;
                            uart_data_write <= ACK;
                            load_error      <= 1'b0;
                        end else begin
                            uart_data_write <= NAK;
                            load_error      <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        csum    <= csum ^ byte_data;
                        addr_sh <= addr_next;
                        idx     <= idx + 2'd1;
                        if (idx == 2'd3) waddr <= addr_next[ADDR_WIDTH+1:2];
                    end
                    S_LEN: begin
                        csum   <= csum ^ byte_data;
                        len_sh <= len_next;
                        if (idx == 2'd1) begin
                            idx     <= 2'd0;
                            len_rem <= len_next;
                        end else begin
                            idx <= 2'd1;
                        end
                    end
                    S_DATA: begin
                        csum    <= csum ^ byte_data;
                        word_sh <= word_next;
                        idx     <= idx + 2'd1;
                        // Words go out immediately; a later bad checksum cannot retract them.
                        if (idx == 2'd3) begin
                            mem_write   <= 1'b1;
                            mem_address <= waddr;
                            mem_data    <= word_next;
                            waddr       <= waddr + 1'b1;
                            len_rem     <= len_rem - 16'd1;
                        end
                    end
                    S_CSUM: begin
                        uart_data_write <= (byte_data == csum) ? ACK : NAK;
                        load_error      <= (byte_data != csum);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Host-side consumer of the UART receive byte stream. It pulls framed bytes out of the UART RX buffer, assembles little-endian 32-bit words, and writes them into MIPS instruction/data memory. It answers each frame with a single ACK/NAK byte pushed into the UART TX buffer, and holds the processor in reset until a RUN command arrives. It sits between the UART's `read`/`data_read`/`data_ready`/`write`/`data_write` ports and the memory write port of the processor top level.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 16: width of the word address driven to memory.
- `TIMEOUT_CYCLES`, default 1_000_000: inter-byte timeout. Used only when the timeout feature is compiled in.

**Ports**
- `clock` in 1: single clock for the block.
- `reset` in 1: asynchronous, active-low reset.
- `uart_data_ready` in 1: RX buffer is non-empty.
- `uart_data_read` in 8: RX buffer output byte. Valid the cycle after `uart_read`.
- `uart_read` out 1: one-cycle pop of the RX buffer.
- `uart_write` out 1: one-cycle push into the TX buffer.
- `uart_data_write` out 8: response byte, valid while `uart_write` is high.
- `mem_write` out 1: one-cycle word write strobe. Memory always accepts it.
- `mem_address` out ADDR_WIDTH: word address.
- `mem_data` out 32: write data.
- `cpu_hold` out 1: holds the processor in reset while high.
- `load_error` out 1: sticky flag, set by any NAK and cleared by the next ACK.

## Operation

- **Frame format:** SYNC `0xA5`, CMD, then a body that depends on CMD.
  - CMD `0x01` (WRITE): ADDR[4] (byte address, LE), LEN[2] (word count, LE), DATA[4*LEN] (LE words), CSUM[1].
  - CMD `0x02` (RUN): no body.
- **CSUM:** XOR of every byte after SYNC up to, but not including, CSUM.
- **State machine:** IDLE → CMD → ADDR → LEN → DATA → CSUM → RESP → IDLE.
  - Any byte other than `0xA5` in IDLE is discarded silently.
  - CMD `0x01` sets `cpu_hold` and enters ADDR.
  - CMD `0x02` clears `cpu_hold` and goes to RESP with ACK.
  - Any other CMD goes to RESP with NAK.
  - LEN = 0 goes straight from LEN to CSUM.
- **Addressing:**
  - Word address = byte address bits [ADDR_WIDTH+1:2]. Low two address bits are ignored.
  - The address increments by 1 after each word and wraps modulo 2^ADDR_WIDTH.
- **Writes are not deferred:** each word is written as soon as its 4th byte arrives. A bad CSUM produces NAK, but already-written words remain in memory.
- **Responses:** ACK = `0x06`, NAK = `0x15`, exactly one per completed frame. TX fullness is not checked; the TX buffer depth covers one byte per frame.
- **Frames after RUN:** further frames are still accepted. A WRITE reasserts `cpu_hold`.

## Timing

- **Reset values:**
  - `uart_read`, `uart_write`, `mem_write`: 0.
  - `uart_data_write`, `mem_address`, `mem_data`: 0.
  - `cpu_hold`: 1.
  - `load_error`: 0.
- **Byte fetch:**
  - With the reader idle, `uart_data_ready` = 1 at edge N gives `uart_read` = 1 during cycle N+1.
  - The byte is sampled at the end of cycle N+2, and the internal `byte_valid` pulses in N+2.
  - There is at most one pop in flight, so at most one byte per 2 cycles.
- **Word write:** `mem_write`, `mem_address` and `mem_data` are registered and asserted the cycle after `byte_valid` of the 4th data byte.
- **Response:** `uart_write` pulses for one cycle, the cycle after `byte_valid` of CSUM (or of CMD for RUN/unknown). The machine returns to IDLE in the same cycle.
- **`cpu_hold`:** changes the cycle after the CMD `byte_valid`.
- **Reset mid-frame:** the frame is abandoned, all outputs return to reset values immediately, and no response is sent.
- **Simultaneous events:** `uart_data_ready` rising while `uart_write` pulses is legal. The fetch proceeds independently.

## Configuration

- **`UART_LOADER_TIMEOUT_EN`** defined:
  - A counter is cleared on every `byte_valid` and increments in all states except IDLE.
  - When it reaches TIMEOUT_CYCLES, the machine aborts to RESP with NAK and sets `load_error`.
- **Undefined:** no counter exists, and a partial frame waits indefinitely.

## Structure

- **Package `uart_loader_pkg`:**
  - Constants: SYNC, CMD_WRITE, CMD_RUN, ACK, NAK.
  - The FSM state enum.
- **Sub-module `uart_loader_byte_reader`:** owns the `uart_read` pop/sample handshake and outputs `byte_valid`/`byte_data`.
- **Top:** holds the FSM, address/length/word shift registers, checksum, and timeout.

## Test plan

- **Good WRITE:** stream A5 01 00 01 00 00 02 00, then words 0x11223344 and 0xAABBCCDD sent LE, then the correct CSUM.
  - Writes: 0x11223344 to word 0x0040, then 0xAABBCCDD to 0x0041.
  - Response byte 06; `cpu_hold` stays 1.
- **Bad CSUM:** same frame with the CSUM byte flipped.
  - Both words are still written.
  - Response 15 and `load_error` = 1.
- **Garbage then RUN:** bytes 00 FF, then A5 02.
  - The garbage produces no response.
  - Response 06 and `cpu_hold` goes to 0 the cycle after CMD.
- **Address wrap, ADDR_WIDTH = 4:** byte address 0x3C, LEN 2.
  - Writes to word 0xF, then to word 0x0.
- **Reset mid-DATA:**
  - `reset` low after 2 data bytes: outputs return to reset values and no TX byte is sent.
  - A following good frame gets ACK.
- **`UART_LOADER_TIMEOUT_EN` with TIMEOUT_CYCLES = 100:** stop the stream after the ADDR bytes.
  - NAK is sent 100 cycles after the last `byte_valid`, and the machine returns to IDLE.
